axi_txn_sequencer: RTL and testbench

Command sequencer that sits directly upstream of the SA AXI4 full master. It accepts one job: mode, start offset and transaction count. It then issues that many single-word master transactions at offsets stepping by ADDR_STEP, using the master's init_txn/txn_done level handshake. STORE jobs pull one 128-bit word per transaction from a valid/ready source. LOAD jobs push one captured word per transaction to a valid/ready sink.

---
 rtl/axi_txn_sequencer.sv | 178 +++++++++++++++++
 tb/tb_axi_txn_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_txn_sequencer.sv
// Job sequencer in front of the SA AXI4 full master: turns one LOAD/STORE job
// into a run of single-word init_txn/txn_done transactions at stepped offsets.
module axi_txn_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int CNT_WIDTH  = 8,
  parameter int ADDR_STEP  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [1:0]            job_mode,
  input  logic [ADDR_WIDTH-1:0] job_addr,
  input  logic [CNT_WIDTH-1:0]  job_count,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            m_mode,
  output logic [ADDR_WIDTH-1:0] m_addra,
  output logic [ADDR_WIDTH-1:0] m_addrb,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  output logic                  m_init_txn,
  input  logic                  m_txn_done,
  input  logic                  m_error,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_WIDTH-1:0]  txn_cnt
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_LOW, ISSUE, RELEASE, PUSH, FINISH
  } state_t;

  localparam logic [1:0] MODE_NONE    = 2'b00;
  localparam logic [1:0] MODE_LOAD    = 2'b01;
  localparam logic [1:0] MODE_STORE   = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);

  state_t                state, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  txn_cnt_d;
  logic                  err_d, init_d, done_d, busy_d;
  logic [1:0]            m_mode_d;
  logic [ADDR_WIDTH-1:0] m_addra_d, m_addrb_d;
  logic [DATA_WIDTH-1:0] m_wdata_d, rd_data_d;

  assign job_ready = (state == IDLE);
  assign wr_ready  = (state == FETCH);
  assign rd_valid  = (state == PUSH);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      mode_q     <= MODE_NONE;
      addr_q     <= '0;
      count_q    <= '0;
      txn_cnt    <= '0;
      err        <= 1'b0;
      m_init_txn <= 1'b0;
      m_mode     <= MODE_NONE;
      m_addra    <= '0;
      m_addrb    <= '0;
      m_wdata    <= '0;
      rd_data    <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      txn_cnt    <= txn_cnt_d;
      err        <= err_d;
      m_init_txn <= init_d;
      m_mode     <= m_mode_d;
      m_addra    <= m_addra_d;
      m_addrb    <= m_addrb_d;
      m_wdata    <= m_wdata_d;
      rd_data    <= rd_data_d;
      done       <= done_d;
      busy       <= busy_d;
    end
  end

  always_comb begin
    state_d   = state;
    mode_d    = mode_q;
    addr_d    = addr_q;
    count_d   = count_q;
    txn_cnt_d = txn_cnt;
    err_d     = err;
    init_d    = m_init_txn;
    m_mode_d  = m_mode;
    m_addra_d = m_addra;
    m_addrb_d = m_addrb;
    m_wdata_d = m_wdata;
    rd_data_d = rd_data;

    case (state)
      IDLE: begin
        if (job_valid) begin
          mode_d    = job_mode;
          addr_d    = job_addr;
          count_d   = job_count;
          txn_cnt_d = '0;
          err_d     = 1'b0;
          if (job_mode == MODE_ILLEGAL) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else if (job_mode == MODE_NONE || job_count == '0) begin
            state_d = FINISH;
          end else if (job_mode == MODE_STORE) begin
            state_d = FETCH;
          end else begin
            state_d = WAIT_LOW;
          end
        end
      end
      FETCH: begin
        if (wr_valid) begin
          m_wdata_d = wr_data;
          state_d   = WAIT_LOW;
        end
      end
      // A done level left over from the previous transaction must fall first.
      WAIT_LOW: begin
        if (!m_txn_done) begin
          init_d    = 1'b1;
          m_mode_d  = mode_q;
          m_addra_d = (mode_q == MODE_STORE) ? addr_q : '0;
          m_addrb_d = (mode_q == MODE_LOAD)  ? addr_q : '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (m_txn_done) begin
          init_d    = 1'b0;
          m_mode_d  = MODE_NONE;
          txn_cnt_d = txn_cnt + 1'b1;
          err_d     = m_error;
          if (mode_q == MODE_LOAD) rd_data_d = m_rdata;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        if (err) begin
          state_d = FINISH;
        end else if (mode_q == MODE_LOAD) begin
          state_d = PUSH;
        end else begin
          addr_d  = addr_q + STEP;
          state_d = (txn_cnt == count_q) ? FINISH : FETCH;
        end
      end
      PUSH: begin
        if (rd_ready) begin
          addr_d  = addr_q + STEP;
          state_d = (txn_cnt == count_q) ? FINISH : WAIT_LOW;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d = (state_d == FINISH);
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_axi_txn_sequencer.sv
// Scoreboard bench for axi_txn_sequencer: behavioural master, source and sink,
// with expectations derived per job from plain offset arithmetic.
module tb_axi_txn_sequencer;

  logic         clk;
  logic         reset_n;
  logic         job_valid;
  logic         job_ready;
  logic [1:0]   job_mode;
  logic [31:0]  job_addr;
  logic [7:0]   job_count;
  logic         wr_valid;
  logic         wr_ready;
  logic [127:0] wr_data;
  logic         rd_valid;
  logic         rd_ready;
  logic [127:0] rd_data;
  logic [1:0]   m_mode;
  logic [31:0]  m_addra;
  logic [31:0]  m_addrb;
  logic [127:0] m_wdata;
  logic [127:0] m_rdata;
  logic         m_init_txn;
  logic         m_txn_done;
  logic         m_error;
  logic         busy;
  logic         done;
  logic         err;
  logic [7:0]   txn_cnt;

  axi_txn_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_mode(job_mode),
    .job_addr(job_addr), .job_count(job_count),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .m_mode(m_mode), .m_addra(m_addra), .m_addrb(m_addrb), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_init_txn(m_init_txn), .m_txn_done(m_txn_done),
    .m_error(m_error), .busy(busy), .done(done), .err(err), .txn_cnt(txn_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] addra;
    logic [31:0] addrb;
    logic [127:0] wdata;
  } txn_t;

  typedef struct {
    logic [7:0] cnt;
    logic       err;
  } done_t;

  txn_t         exp_txn[$];
  logic [127:0] exp_rd[$];
  done_t        exp_done[$];
  logic [127:0] src_q[$];

  int checks   = 0;
  int failures = 0;

  int cfg_d       = 5;
  int cfg_hold    = 0;
  int cfg_err_txn = 0;
  int cfg_stall   = 0;
  int txn_idx     = 0;
  int init_rises  = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural master: done level some cycles after init, held until init drops plus an optional tail.
  initial begin
    int phase;
    int cnt;
    phase = 0;
    cnt = 0;
    m_txn_done = 1'b0;
    m_error = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        phase = 0;
        m_txn_done = 1'b0;
        m_error = 1'b0;
      end else begin
        case (phase)
          0: if (m_init_txn) begin
            txn_idx++;
            cnt = 1;
            phase = 1;
          end
          1: if (cnt >= cfg_d) begin
            m_rdata = {96'd0, m_addrb} * 128'd3;
            m_error = (txn_idx == cfg_err_txn);
            m_txn_done = 1'b1;
            phase = 2;
          end else begin
            cnt++;
          end
          2: if (!m_init_txn) begin
            m_error = 1'b0;
            if (cfg_hold == 0) begin
              m_txn_done = 1'b0;
              phase = 0;
            end else begin
              cnt = cfg_hold;
              phase = 3;
            end
          end
          default: begin
            cnt--;
            if (cnt <= 0) begin
              m_txn_done = 1'b0;
              phase = 0;
            end
          end
        endcase
      end
    end
  end

  // Store data source with random bubbles; garbage on wr_data while not valid.
  initial begin
    logic take;
    wr_valid = 1'b0;
    wr_data = '0;
    forever begin
      @(negedge clk);
      take = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      if (take && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0 && $urandom_range(3) != 0) begin
        wr_valid = 1'b1;
        wr_data = src_q[0];
      end else begin
        wr_valid = 1'b0;
        wr_data = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Load sink: stalls cfg_stall cycles before accepting each word.
  initial begin
    int sc;
    sc = 0;
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rd_valid) begin
        rd_ready = 1'b0;
        sc = 0;
      end else if (sc < cfg_stall) begin
        rd_ready = 1'b0;
        sc++;
      end else begin
        rd_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT shows a transaction, a load word or done.
  initial begin
    logic prev_init;
    logic [1:0] cur_mode;
    txn_t t;
    done_t dn;
    prev_init = 1'b0;
    cur_mode = 2'b00;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_init = 1'b0;
      end else begin
        if (m_init_txn && !prev_init) begin
          init_rises++;
          checkOutput("init_while_done", 128'(m_txn_done), 128'd0);
          if (exp_txn.size() == 0) begin
            checkOutput("unexpected_txn", 128'd1, 128'd0);
          end else begin
            t = exp_txn.pop_front();
            cur_mode = t.mode;
            checkOutput("m_addra", 128'(m_addra), 128'(t.addra));
            checkOutput("m_addrb", 128'(m_addrb), 128'(t.addrb));
            if (t.mode == 2'b10) checkOutput("m_wdata", m_wdata, t.wdata);
          end
        end
        if (m_init_txn) checkOutput("m_mode_issue", 128'(m_mode), 128'(cur_mode));
        if (rd_valid) checkOutput("init_in_push", 128'(m_init_txn), 128'd0);
        if (rd_valid && rd_ready) begin
          if (exp_rd.size() == 0) checkOutput("unexpected_rd", 128'd1, 128'd0);
          else checkOutput("rd_data", rd_data, exp_rd.pop_front());
        end
        if (done) begin
          if (exp_done.size() == 0) begin
            checkOutput("unexpected_done", 128'd1, 128'd0);
          end else begin
            dn = exp_done.pop_front();
            checkOutput("done_txn_cnt", 128'(txn_cnt), 128'(dn.cnt));
            checkOutput("done_err", 128'(err), 128'(dn.err));
          end
        end
        prev_init = m_init_txn;
      end
    end
  end

  // Builds the expected outcome of one job from offset arithmetic, then runs it to completion.
  task automatic applyStimulus(input logic [1:0] mode, input logic [31:0] addr, input int count,
                               input int d, input int hold, input int err_txn, input int stall,
                               input bit squares);
    int n_txn;
    int rises0;
    bit job_err;
    logic [31:0] a;
    logic [127:0] w;
    logic [31:0] i;
    txn_t t;
    done_t dn;
    cfg_d = d;
    cfg_hold = hold;
    cfg_err_txn = err_txn;
    cfg_stall = stall;
    txn_idx = 0;
    job_err = 1'b0;
    n_txn = 0;
    if (mode == 2'b11) begin
      job_err = 1'b1;
    end else if (mode != 2'b00 && count != 0) begin
      if (err_txn >= 1 && err_txn <= count) begin
        n_txn = err_txn;
        job_err = 1'b1;
      end else begin
        n_txn = count;
      end
    end
    for (int k = 0; k < n_txn; k++) begin
      a = addr + 32'(k) * 32'd16;
      i = 32'h0F0 - 32'(k) * 32'h10;
      w = squares ? 128'(i * i) : {$urandom, $urandom, $urandom, $urandom};
      t.mode = mode;
      t.addra = (mode == 2'b10) ? a : 32'd0;
      t.addrb = (mode == 2'b01) ? a : 32'd0;
      t.wdata = w;
      exp_txn.push_back(t);
      if (mode == 2'b10) src_q.push_back(w);
      if (mode == 2'b01 && !(job_err && k == n_txn - 1)) exp_rd.push_back(128'(a) * 128'd3);
    end
    dn.cnt = 8'(n_txn);
    dn.err = job_err;
    exp_done.push_back(dn);
    rises0 = init_rises;

    @(posedge clk);
    #1;
    checkOutput("job_ready_idle", 128'(job_ready), 128'd1);
    job_valid = 1'b1;
    job_mode = mode;
    job_addr = addr;
    job_count = 8'(count);
    @(posedge clk);
    #1;
    job_valid = 1'b0;
    job_mode = 2'($urandom);
    job_addr = $urandom;
    job_count = 8'($urandom);
    if (n_txn == 0) begin
      @(negedge clk);
      checkOutput("quick_done", 128'(done), 128'd1);
    end
    for (int c = 0; c < 20000 && exp_done.size() != 0; c++) @(negedge clk);
    if (exp_done.size() != 0) begin
      checkOutput("job_timeout", 128'(exp_done.size()), 128'd0);
      exp_done.delete();
    end
    repeat (hold + 3) @(negedge clk);
    checkOutput("init_count", 128'(init_rises - rises0), 128'(n_txn));
    checkOutput("txn_left", 128'(exp_txn.size()), 128'd0);
    checkOutput("rd_left", 128'(exp_rd.size()), 128'd0);
    checkOutput("sticky_txn_cnt", 128'(txn_cnt), 128'(n_txn));
    checkOutput("sticky_err", 128'(err), 128'(job_err));
    checkOutput("busy_after", 128'(busy), 128'd0);
    exp_txn.delete();
    exp_rd.delete();
    src_q.delete();
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0;
    job_valid = 1'b0;
    job_mode = 2'b00;
    job_addr = '0;
    job_count = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("reset_busy", 128'(busy), 128'd0);
      checkOutput("reset_job_ready", 128'(job_ready), 128'd1);
      checkOutput("reset_init", 128'(m_init_txn), 128'd0);
      checkOutput("reset_m_mode", 128'(m_mode), 128'd0);
      checkOutput("reset_done", 128'(done), 128'd0);
      checkOutput("reset_txn_cnt", 128'(txn_cnt), 128'd0);
      checkOutput("reset_rd_valid", 128'(rd_valid), 128'd0);
    end

    applyStimulus(2'b10, 32'h0000_00F0, 16, 5, 0, 0, 0, 1'b1);
    applyStimulus(2'b01, 32'h0000_0000, 16, 5, 0, 0, 3, 1'b0);
    applyStimulus(2'b10, 32'h0000_1000, 0, 2, 0, 0, 0, 1'b0);
    applyStimulus(2'b11, 32'h0000_2000, 5, 2, 0, 0, 0, 1'b0);
    applyStimulus(2'b00, 32'h0000_3000, 3, 2, 0, 0, 0, 1'b0);
    applyStimulus(2'b01, 32'hFFFF_FFF0, 2, 3, 0, 0, 1, 1'b0);
    applyStimulus(2'b10, 32'h0000_4000, 3, 2, 4, 0, 0, 1'b0);
    applyStimulus(2'b10, 32'h0000_5000, 8, 3, 0, 3, 0, 1'b0);
    applyStimulus(2'b01, 32'h0000_6000, 5, 2, 1, 2, 2, 1'b0);

    for (int r = 0; r < 8; r++) begin
      applyStimulus($urandom_range(1) ? 2'b10 : 2'b01, $urandom, int'($urandom_range(6, 1)),
                    int'($urandom_range(4, 1)), int'($urandom_range(2)),
                    ($urandom_range(3) == 0) ? int'($urandom_range(4, 1)) : 0,
                    int'($urandom_range(3)), 1'b0);
    end

    // Abandon a job with reset while its transaction is outstanding.
    cfg_d = 6;
    cfg_hold = 0;
    cfg_err_txn = 0;
    txn_idx = 0;
    for (int k = 0; k < 8; k++) src_q.push_back(128'(k));
    @(posedge clk);
    #1;
    job_valid = 1'b1;
    job_mode = 2'b10;
    job_addr = 32'h0000_7000;
    job_count = 8'd8;
    @(posedge clk);
    #1;
    job_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(posedge clk);
      #1;
      seen = m_init_txn;
    end
    checkOutput("reset_job_issued", 128'(seen), 128'd1);
    exp_txn.delete();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midjob_init", 128'(m_init_txn), 128'd0);
    checkOutput("midjob_busy", 128'(busy), 128'd0);
    checkOutput("midjob_done", 128'(done), 128'd0);
    checkOutput("midjob_job_ready", 128'(job_ready), 128'd1);
    src_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_reset_done", 128'(done), 128'd0);
    end

    applyStimulus(2'b01, 32'h0000_8000, 2, 2, 0, 0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
